// File: rtl/au_pkg.sv
// Shared types and sizing helpers for the arithmetic-unit library.
package au_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } au_state_e;

  // Number of digit steps for a word, guarded against a zero digit so a bad
  // parameter reaches the legality check instead of failing on a divide.
  function automatic int unsigned ncyc_f(input int unsigned width, input int unsigned digit);
    return (digit == 0) ? 1 : (width + digit - 1) / digit;
  endfunction

  function automatic int unsigned cnt_w_f(input int unsigned ncyc);
    return (ncyc <= 1) ? 1 : $clog2(ncyc);
  endfunction

endpackage

// File: rtl/au_add_cz_digit.sv
// Combinational DIGIT-bit ripple slice; exposes the carry out of every bit
// so the parent can pick the carry at a partial-digit boundary.
module au_add_cz_digit #(
  parameter int unsigned DIGIT = 2
) (
  input  logic [DIGIT-1:0] x,
  input  logic [DIGIT-1:0] y,
  input  logic             cin,
  output logic [DIGIT-1:0] sum,
  output logic [DIGIT-1:0] carry
);

  always_comb begin
    logic c;
    c     = cin;
    sum   = '0;
    carry = '0;
    for (int i = 0; i < DIGIT; i++) begin
      sum[i]   = x[i] ^ y[i] ^ c;
      carry[i] = (x[i] & y[i]) | (c & (x[i] ^ y[i]));
      c        = carry[i];
    end
  end

endmodule

// File: rtl/au_add_cz_serial.sv
// Digit-serial adder: s/co = a + b + ci, DIGIT bits per clock, with zero flag
// and valid/ready handshakes on both sides.
module au_add_cz_serial
  import au_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DIGIT = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             ci,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] s,
  output logic             co,
  output logic             z
);

  localparam int unsigned NCYC    = ncyc_f(WIDTH, DIGIT);
  localparam int unsigned EW      = NCYC * DIGIT;
  localparam int unsigned CW      = cnt_w_f(NCYC);
  localparam int unsigned LASTPOS = (DIGIT == 0) ? 0 : (WIDTH - 1) % DIGIT;
  localparam logic [CW-1:0] LAST_CNT = CW'(NCYC - 1);

  generate
    if (WIDTH < 1 || DIGIT < 1 || DIGIT > WIDTH) begin : g_bad_param
      $fatal(1, "au_add_cz_serial: illegal WIDTH=%0d DIGIT=%0d", WIDTH, DIGIT);
    end
  endgenerate

  au_state_e        state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             carry_q, carry_d;
  logic [WIDTH-1:0] s_d;
  logic             co_d, z_d, out_valid_d;

  logic [31:0]      shamt;
  logic [DIGIT-1:0] dx, dy, dsum, dcarry;
  logic [EW-1:0]    s_ext;
  logic [WIDTH-1:0] s_calc;
  logic             cout_c, co_last_c;

  // Select the current digit of the zero-extended operands and merge its sum into s.
  always_comb begin
    shamt     = 32'(cnt_q) * 32'(DIGIT);
    dx        = DIGIT'(EW'(a_q) >> shamt);
    dy        = DIGIT'(EW'(b_q) >> shamt);
    s_ext     = (EW'(s) & ~(EW'({DIGIT{1'b1}}) << shamt)) | (EW'(dsum) << shamt);
    s_calc    = WIDTH'(s_ext);
    cout_c    = 1'(dcarry >> (DIGIT - 1));
    co_last_c = 1'(dcarry >> LASTPOS);
  end

  au_add_cz_digit #(.DIGIT(DIGIT)) u_digit (
    .x     (dx),
    .y     (dy),
    .cin   (carry_q),
    .sum   (dsum),
    .carry (dcarry)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    a_d         = a_q;
    b_d         = b_q;
    cnt_d       = cnt_q;
    carry_d     = carry_q;
    s_d         = s;
    co_d        = co;
    z_d         = z;
    out_valid_d = out_valid;
    in_ready    = 1'b0;
    unique case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          a_d     = a;
          b_d     = b;
          carry_d = ci;
          cnt_d   = '0;
          state_d = CALC;
        end
      end
      CALC: begin
        s_d     = s_calc;
        carry_d = cout_c;
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == LAST_CNT) begin
          co_d        = co_last_c;
          z_d         = ~(co_last_c | (|s_calc));
          out_valid_d = 1'b1;
          state_d     = DONE;
        end
      end
      DONE: begin
        // Combinational pass-through lets a new operand pair enter as the result leaves.
        in_ready = out_ready;
        if (out_ready) begin
          out_valid_d = 1'b0;
          if (in_valid) begin
            a_d     = a;
            b_d     = b;
            carry_d = ci;
            cnt_d   = '0;
            state_d = CALC;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q       <= '0;
      b_q       <= '0;
      cnt_q     <= '0;
      carry_q   <= 1'b0;
      s         <= '0;
      co        <= 1'b0;
      z         <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      a_q       <= a_d;
      b_q       <= b_d;
      cnt_q     <= cnt_d;
      carry_q   <= carry_d;
      s         <= s_d;
      co        <= co_d;
      z         <= z_d;
      out_valid <= out_valid_d;
    end
  end

endmodule

// File: tb/tb_au_add_cz_serial.sv
// Scoreboard bench for au_add_cz_serial across several WIDTH/DIGIT configurations.
module tb_au_add_cz_serial;

  localparam int NCFG  = 8;
  localparam int N_OPS = 1250;

  function automatic int unsigned cfg_w(input int i);
    case (i)
      0: return 8;
      1: return 7;
      2: return 1;
      3: return 8;
      4: return 8;
      5: return 13;
      6: return 13;
      default: return 13;
    endcase
  endfunction

  function automatic int unsigned cfg_d(input int i);
    case (i)
      0: return 2;
      1: return 3;
      2: return 1;
      3: return 1;
      4: return 8;
      5: return 1;
      6: return 3;
      default: return 13;
    endcase
  endfunction

  logic clk;
  int   cyc;
  int   total;
  int   bad;
  wire [NCFG-1:0] done_vec;

  initial begin
    clk   = 1'b0;
    cyc   = 0;
    total = 0;
    bad   = 0;
  end
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int g, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL cfg%0d %s: got %0h expected %0h (cycle %0d)", g, nm, act, exp, cyc);
    end
  endtask

  for (genvar g = 0; g < NCFG; g++) begin : g_cfg
    localparam int          G  = g;
    localparam int unsigned W  = cfg_w(g);
    localparam int unsigned D  = cfg_d(g);
    localparam int          NC = int'((W + D - 1) / D);

    logic         rst_n, in_valid, in_ready, ci, out_valid, out_ready, co, z;
    logic [W-1:0] a, b, s;
    logic [W:0]   exp_q[$];
    int           acc_q[$];
    logic         drv_done, done_b;

    assign done_vec[g] = done_b;

    au_add_cz_serial #(.WIDTH(W), .DIGIT(D)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .ci        (ci),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .s         (s),
      .co        (co),
      .z         (z)
    );

    // Consumer: random back-pressure, including multi-cycle stalls.
    initial begin
      int stall;
      stall     = 0;
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        if (stall > 0) begin
          out_ready = 1'b0;
          stall--;
        end else if ($urandom_range(0, 3) == 0) begin
          out_ready = 1'b0;
          stall     = int'($urandom_range(0, 5));
        end else begin
          out_ready = 1'b1;
        end
      end
    end

    // Producer: reset checks, directed operands, then random traffic.
    initial begin
      logic [W-1:0] va, vb;
      logic         vc;
      int           waitc;
      rst_n    = 1'b0;
      in_valid = 1'b0;
      a        = '0;
      b        = '0;
      ci       = 1'b0;
      drv_done = 1'b0;
      #1;
      chk("rst_out_valid", G, longint'(out_valid), 0);
      chk("rst_s", G, longint'(s), 0);
      chk("rst_co_z", G, longint'({co, z}), 0);
      chk("rst_in_ready", G, longint'(in_ready), 1);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;

      // Reset while the sum is being built: no result may escape.
      @(negedge clk);
      in_valid = 1'b1;
      a        = '1;
      b        = '1;
      ci       = 1'b1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 1'b0;
      if (NC > 1) begin
        @(posedge clk);
        @(negedge clk);
      end
      #1 rst_n = 1'b0;
      #1;
      chk("midreset_out_valid", G, longint'(out_valid), 0);
      chk("midreset_s", G, longint'(s), 0);
      chk("midreset_co_z", G, longint'({co, z}), 0);
      chk("midreset_in_ready", G, longint'(in_ready), 1);
      @(negedge clk);
      rst_n = 1'b1;
      #1 chk("postreset_in_ready", G, longint'(in_ready), 1);

      for (int n = 0; n < N_OPS; n++) begin
        while ($urandom_range(0, 3) == 0) begin
          in_valid = 1'b0;
          a        = W'($urandom);
          b        = W'($urandom);
          ci       = 1'($urandom);
          @(negedge clk);
        end
        case ($urandom_range(0, 5))
          0:       va = '1;
          1:       va = '0;
          default: va = W'($urandom);
        endcase
        case ($urandom_range(0, 5))
          0:       vb = '1;
          1:       vb = '0;
          default: vb = W'($urandom);
        endcase
        vc = 1'($urandom);
        if (W == 8 && D == 2 && n < 3) begin
          case (n)
            0:       begin va = W'(8'h00); vb = W'(8'h00); vc = 1'b0; end
            1:       begin va = W'(8'hFF); vb = W'(8'h01); vc = 1'b0; end
            default: begin va = W'(8'hFF); vb = W'(8'hFF); vc = 1'b1; end
          endcase
        end
        if (W == 7 && D == 3 && n < 2) begin
          if (n == 0) begin va = W'(8'h7F); vb = W'(8'h01); vc = 1'b0; end
          else        begin va = W'(8'h40); vb = W'(8'h3F); vc = 1'b0; end
        end
        in_valid = 1'b1;
        a        = va;
        b        = vb;
        ci       = vc;
        #2;
        waitc = 0;
        while (!in_ready && waitc < 200) begin
          @(negedge clk);
          #2;
          waitc++;
        end
        if (!in_ready) begin
          total++;
          bad++;
          $display("FAIL cfg%0d in_ready_timeout: got 0 expected 1 (cycle %0d)", G, cyc);
        end else begin
          exp_q.push_back((W+1)'(va) + (W+1)'(vb) + (W+1)'(vc));
          acc_q.push_back(cyc + 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        a        = W'($urandom);
        b        = W'($urandom);
      end
      drv_done = 1'b1;
    end

    // Monitor: compare every presented result against the queued reference.
    initial begin
      int         waitc;
      bit         seen;
      logic [W:0] e;
      waitc  = 0;
      seen   = 1'b0;
      done_b = 1'b0;
      forever begin
        @(negedge clk);
        #3;
        if (rst_n) begin
          if (exp_q.size() == 0) begin
            chk("spurious_valid", G, longint'(out_valid), 0);
            if (drv_done) done_b = 1'b1;
          end else if (out_valid) begin
            e = exp_q[0];
            chk("sum", G, longint'(s), longint'(e[W-1:0]));
            chk("carry", G, longint'(co), longint'(e[W]));
            chk("zero", G, longint'(z), longint'(e == '0));
            chk("in_ready_done", G, longint'(in_ready), longint'(out_ready));
            if (!seen) begin
              chk("latency", G, longint'(cyc - acc_q[0]), longint'(NC));
              seen = 1'b1;
            end
            if (out_ready) begin
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              seen  = 1'b0;
              waitc = 0;
            end
          end else begin
            waitc++;
            if (waitc > NC + 2) begin
              total++;
              bad++;
              $display("FAIL cfg%0d out_valid_timeout: waited %0d cycles, limit %0d", G, waitc, NC + 2);
              void'(exp_q.pop_front());
              void'(acc_q.pop_front());
              seen  = 1'b0;
              waitc = 0;
            end
          end
        end
      end
    end
  end

  initial begin
    while (done_vec != '1 && cyc < 95000) @(negedge clk);
    if (done_vec != '1) begin
      total++;
      bad++;
      $display("FAIL global_timeout: done=%b required all ones", done_vec);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
